// File: rtl/uart_transmitter.sv
// 8N1/8N2 UART transmitter with a valid/ready byte input and a one-entry holding buffer
// so that consecutive frames can be sent with no idle time between them.
module uart_transmitter #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned TICK_CNT  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TICK_BITS = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [TICK_BITS-1:0] TickLast = TICK_BITS'(TICK_CNT - 1);
  localparam logic StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic [7:0]           shift_q;
  logic [7:0]           buf_q;
  logic                 buf_full_q;
  logic [2:0]           bit_idx_q;
  logic [TICK_BITS-1:0] tick_q;
  logic                 stop_idx_q;
  logic                 tx_q;
  logic                 busy_q;

  logic xfer;
  logic tick_done;
  logic stop_end_empty;
  logic load_direct;

  assign ready     = !buf_full_q;
  assign xfer      = data_valid && ready;
  assign tick_done = (tick_q == '0);

  // Last cycle of the last stop bit with nothing buffered: a new byte may start immediately.
  assign stop_end_empty = (state_q == StStop) && tick_done && (stop_idx_q == StopLast) &&
                          !buf_full_q;
  assign load_direct    = xfer && ((state_q == StIdle) || stop_end_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_idx_q  <= '0;
      tick_q     <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (xfer && !load_direct) begin
        buf_q      <= data_in;
        buf_full_q <= 1'b1;
      end

      if (load_direct) begin
        shift_q <= data_in;
        state_q <= StStart;
        tick_q  <= TickLast;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StStart: begin
            if (tick_done) begin
              state_q   <= StData;
              bit_idx_q <= '0;
              tick_q    <= TickLast;
              tx_q      <= shift_q[0];
            end else begin
              tick_q <= tick_q - 1'b1;
            end
          end
          StData: begin
            if (tick_done) begin
              tick_q <= TickLast;
              if (bit_idx_q == 3'd7) begin
                state_q    <= StStop;
                stop_idx_q <= 1'b0;
                tx_q       <= 1'b1;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
                tx_q      <= shift_q[bit_idx_q + 3'd1];
              end
            end else begin
              tick_q <= tick_q - 1'b1;
            end
          end
          StStop: begin
            if (tick_done) begin
              tick_q <= TickLast;
              if (stop_idx_q == StopLast) begin
                if (buf_full_q) begin
                  // Drain the holding buffer straight into the next start bit.
                  shift_q    <= buf_q;
                  buf_full_q <= 1'b0;
                  state_q    <= StStart;
                  tx_q       <= 1'b0;
                end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                end
              end else begin
                stop_idx_q <= 1'b1;
              end
            end else begin
              tick_q <= tick_q - 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
